blk_alloc_ctrl: RTL

Block-allocation controller that sits directly downstream of the free-block bitmap. It takes the bitmap's lowest free block address, marks that block used through bitmap write port 1, and queues the address in a small prefetch FIFO. Cache write ports draw block addresses from that FIFO. Freed blocks from the read/release path are forwarded to bitmap write port 2 as clears.

---
 rtl/blk_alloc_pkg.sv | 7 +
 rtl/blk_alloc_ctrl_pf_fifo.sv | 50 +++++
 rtl/blk_alloc_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/blk_alloc_pkg.sv
// blk_alloc_pkg: shared FSM encoding and bitmap write constants for the block allocator.
package blk_alloc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_WAIT} state_e;
    localparam int SETTLE_MIN = 2;
    localparam logic SET_VAL = 1'b1;
    localparam logic CLR_VAL = 1'b0;
endpackage

// File: rtl/blk_alloc_ctrl_pf_fifo.sv
// alloc_pf_fifo: show-ahead FIFO holding pre-marked free block addresses.
module alloc_pf_fifo #(
    parameter int W = 10,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          empty
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;

    // a push into a full FIFO is accepted only when the same cycle pops
    always_comb begin
        do_pop = pop && (count_q != '0);
        do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end

    assign head = mem_q[rd_q];
    assign count = count_q;
    assign empty = (count_q == '0);
endmodule

// File: rtl/blk_alloc_ctrl.sv
// blk_alloc_ctrl: marks the bitmap's lowest free block used, prefetches it for cache
// writers, and forwards released blocks to the bitmap as clears.
module blk_alloc_ctrl
    import blk_alloc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int PF_DEPTH = 4,
    parameter int SETTLE = 2,
    localparam int CW = $clog2(PF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bm_emp_addr,
    input  logic              bm_emp_vld,
    output logic              bm_set_en,
    output logic [ADDR_W-1:0] bm_set_addr,
    output logic              bm_set_val,
    output logic              bm_clr_en,
    output logic [ADDR_W-1:0] bm_clr_addr,
    output logic              bm_clr_val,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_empty,
    input  logic              free_vld,
    input  logic [ADDR_W-1:0] free_addr,
    output logic [CW-1:0]     pf_count,
    output logic [ADDR_W:0]   held_cnt
);
    localparam int SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
    localparam int SW = $clog2(SETTLE_EFF);

    state_e state_q, state_d;
    logic [ADDR_W-1:0] set_addr_q, set_addr_d, clr_addr_q, clr_addr_d;
    logic [SW-1:0] settle_q, settle_d;
    logic clr_en_q, clr_en_d;
    logic [ADDR_W:0] held_cnt_q, held_cnt_d;
    logic fifo_empty, room;

    alloc_pf_fifo #(.W(ADDR_W), .DEPTH(PF_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(state_q == ST_MARK),
        .din(set_addr_q),
        .pop(alloc_gnt),
        .head(alloc_addr),
        .count(pf_count),
        .empty(fifo_empty)
    );

    assign alloc_gnt = alloc_req && !fifo_empty;
    assign alloc_empty = fifo_empty;
    assign room = (pf_count - CW'(alloc_gnt)) < CW'(PF_DEPTH);

    // the bitmap's free address lags a mark by two stages, so WAIT hides it
    always_comb begin
        state_d = state_q;
        set_addr_d = set_addr_q;
        settle_d = settle_q;
        unique case (state_q)
            ST_IDLE: if (bm_emp_vld && room) begin
                set_addr_d = bm_emp_addr;
                state_d = ST_MARK;
            end
            ST_MARK: begin
                settle_d = SW'(SETTLE_EFF - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: if (settle_q == '0) state_d = ST_IDLE;
                     else settle_d = settle_q - 1'b1;
            default: state_d = ST_IDLE;
        endcase
        clr_en_d = free_vld;
        clr_addr_d = free_addr;
        held_cnt_d = (alloc_gnt && !free_vld) ? held_cnt_q + 1'b1 :
                     (free_vld && !alloc_gnt && held_cnt_q != '0) ? held_cnt_q - 1'b1 :
                     held_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            set_addr_q <= '0;
            settle_q <= '0;
            clr_en_q <= 1'b0;
            clr_addr_q <= '0;
            held_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            set_addr_q <= set_addr_d;
            settle_q <= settle_d;
            clr_en_q <= clr_en_d;
            clr_addr_q <= clr_addr_d;
            held_cnt_q <= held_cnt_d;
        end
    end

    assign bm_set_en = (state_q == ST_MARK);
    assign bm_set_addr = set_addr_q;
    assign bm_set_val = SET_VAL;
    assign bm_clr_en = clr_en_q;
    assign bm_clr_addr = clr_addr_q;
    assign bm_clr_val = CLR_VAL;
    assign held_cnt = held_cnt_q;
endmodule
